// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 tristate bus. Drives the mux select and
// per-driver enables with a one-cycle turnaround; a hold timer forces release of long owners.
module tristate_bus_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic [3:0] en,
    output logic       busy,
    output logic       timeout
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_OWN,
        S_RELEASE
    } state_t;

    state_t          r_state;
    logic   [1:0]    r_owner;
    logic   [1:0]    r_last;
    logic   [CW-1:0] r_hold;
    logic   [3:0]    r_gnt;
    logic   [1:0]    r_sel;
    logic   [3:0]    r_en;
    logic            r_busy;
    logic            r_timeout;

    state_t          w_state_nx;
    logic   [1:0]    w_owner_nx;
    logic   [1:0]    w_last_nx;
    logic   [CW-1:0] w_hold_nx;
    logic   [1:0]    w_pick;
    logic   [3:0]    w_onehot;
    logic            w_timeout_nx;

    // Offsets are scanned from farthest to nearest so the nearest requester after last wins.
    function automatic logic [1:0] f_pick(input logic [3:0] rq, input logic [1:0] lst);
        logic [1:0] idx;
        f_pick = 2'(lst + 2'd1);
        for (int i = 4; i >= 1; i--) begin
            idx = 2'(lst + 2'(i));
            if (rq[idx]) f_pick = idx;
        end
    endfunction

    assign w_pick   = f_pick(req, r_last);
    assign w_onehot = 4'(4'b0001 << w_owner_nx);

    always_comb begin
        w_state_nx   = r_state;
        w_owner_nx   = r_owner;
        w_last_nx    = r_last;
        w_hold_nx    = r_hold;
        w_timeout_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nx = S_GRANT;
                    w_owner_nx = w_pick;
                end
            end
            S_GRANT: begin
                if (req[r_owner]) begin
                    w_state_nx = S_OWN;
                    w_hold_nx  = CW'(1);
                end else begin
                    w_state_nx = S_RELEASE;
                    w_last_nx  = r_owner;
                end
            end
            S_OWN: begin
                // A voluntary exit outranks the hold limit, so no timeout in that case.
                if (done || !req[r_owner]) begin
                    w_state_nx = S_RELEASE;
                    w_last_nx  = r_owner;
                end else if (r_hold == CW'(MAX_HOLD)) begin
                    w_state_nx   = S_RELEASE;
                    w_last_nx    = r_owner;
                    w_timeout_nx = 1'b1;
                end else begin
                    w_hold_nx = r_hold + CW'(1);
                end
            end
            S_RELEASE: begin
                w_hold_nx = '0;
                if (|req) begin
                    w_state_nx = S_GRANT;
                    w_owner_nx = w_pick;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_owner   <= 2'd0;
            r_last    <= 2'd3;
            r_hold    <= '0;
            r_gnt     <= 4'b0000;
            r_sel     <= 2'd0;
            r_en      <= 4'b0000;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_owner   <= w_owner_nx;
            r_last    <= w_last_nx;
            r_hold    <= w_hold_nx;
            r_timeout <= w_timeout_nx;
            r_busy    <= (w_state_nx != S_IDLE);
            r_gnt     <= (w_state_nx == S_GRANT || w_state_nx == S_OWN) ? w_onehot : 4'b0000;
            r_en      <= (w_state_nx == S_OWN) ? w_onehot : 4'b0000;
            if (w_state_nx == S_IDLE)       r_sel <= 2'd0;
            else if (w_state_nx == S_GRANT) r_sel <= w_owner_nx;
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign en      = r_en;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
